// File: rtl/axis_csum_append_if.sv
// Stream bundle for axis_csum_append: upstream write side and downstream read side.
// The slave modport is the block's view; master is the surrounding environment.
interface axis_csum_append_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] writeData;
  logic                 writeDataValid;
  logic                 writeDataReady;
  logic                 writeDataLast;
  logic [DataWidth-1:0] readData;
  logic                 readDataValid;
  logic                 readDataReady;
  logic                 readDataLast;

  modport slave (
    input  writeData,
    input  writeDataValid,
    input  writeDataLast,
    input  readDataReady,
    output writeDataReady,
    output readData,
    output readDataValid,
    output readDataLast
  );

  modport master (
    output writeData,
    output writeDataValid,
    output writeDataLast,
    output readDataReady,
    input  writeDataReady,
    input  readData,
    input  readDataValid,
    input  readDataLast
  );
endinterface

// File: rtl/axis_csum_append.sv
// Forwards stream words unchanged and appends a per-frame modular sum trailer.
// Single output register; one input bubble per frame while the trailer loads.
module axis_csum_append #(
  parameter int DataWidth  = 32,
  parameter int CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  axis_csum_append_if.slave     bus,
  output logic [CountWidth-1:0] frameCount,
  output logic [CountWidth-1:0] wordCount
);

  typedef enum logic {
    PASS,
    TRAIL
  } state_t;

  state_t               state;
  state_t               stateN;
  logic [DataWidth-1:0] oData;
  logic [DataWidth-1:0] oDataN;
  logic [DataWidth-1:0] sum;
  logic [DataWidth-1:0] sumN;
  logic                 oValid;
  logic                 oValidN;
  logic                 oLast;
  logic                 oLastN;
  logic [CountWidth-1:0] frameCountN;
  logic [CountWidth-1:0] wordCountN;
  logic                 slotFree;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= PASS;
      oData      <= '0;
      oValid     <= 1'b0;
      oLast      <= 1'b0;
      sum        <= '0;
      frameCount <= '0;
      wordCount  <= '0;
    end else begin
      state      <= stateN;
      oData      <= oDataN;
      oValid     <= oValidN;
      oLast      <= oLastN;
      sum        <= sumN;
      frameCount <= frameCountN;
      wordCount  <= wordCountN;
    end
  end

  always_comb begin
    slotFree           = !oValid || bus.readDataReady;
    bus.writeDataReady = reset && (state == PASS) && slotFree;
    accept             = bus.writeDataReady && bus.writeDataValid;
    stateN      = state;
    oDataN      = oData;
    oValidN     = oValid;
    oLastN      = oLast;
    sumN        = sum;
    frameCountN = frameCount;
    wordCountN  = wordCount;
    unique case (1'b1)
      accept: begin
        oDataN     = bus.writeData;
        oLastN     = 1'b0;
        oValidN    = 1'b1;
        sumN       = sum + bus.writeData;
        wordCountN = (&wordCount) ? wordCount
                                  : wordCount + CountWidth'(1);
        if (bus.writeDataLast)
          stateN = TRAIL;
      end
      (state == PASS) && slotFree && !accept: begin
        oValidN = 1'b0;
      end
      // sum already holds the last data word; it can load while that word leaves
      (state == TRAIL) && slotFree: begin
        oDataN      = sum;
        oLastN      = 1'b1;
        oValidN     = 1'b1;
        sumN        = '0;
        wordCountN  = '0;
        frameCountN = frameCount + CountWidth'(1);
        stateN      = PASS;
      end
      default: ;
    endcase
  end

  assign bus.readData      = oData;
  assign bus.readDataValid = oValid;
  assign bus.readDataLast  = oLast;

endmodule

// File: doc/axis_csum_append.md
Name: axis_csum_append

Overview:
- Downstream AXI-Stream stage placed directly after the fifo_top output (readData/readDataValid/readDataReady/readDataLast).
- Forwards every data word of a frame unchanged.
- After the last word of each frame, it appends one trailer word: the modulo-2^DataWidth sum of all data words in that frame. The trailer carries Last.
- Keeps a running count of completed frames for status and debug.

Parameters:
- DataWidth, 32, width of data words and of the trailer sum.
- CountWidth, 16, width of frameCount and of the per-frame word counter.

Ports:
- clk  input  1  single clock; everything is rising-edge.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- writeData  input  DataWidth  input stream data.
- writeDataValid  input  1  input valid.
- writeDataReady  output  1  input ready.
- writeDataLast  input  1  marks the final data word of a frame.
- readData  output  DataWidth  output stream data (data word or trailer).
- readDataValid  output  1  output valid.
- readDataReady  input  1  output ready from the downstream consumer.
- readDataLast  output  1  asserted only on the trailer word.
- frameCount  output  CountWidth  number of trailers loaded since reset. Wraps modulo 2^CountWidth.
- wordCount  output  CountWidth  data words accepted in the current frame. Saturates at all-ones.

Behaviour:
- Reset (reset==0 at a clk edge):
  - readDataValid=0, readDataLast=0, readData=0.
  - sum=0, wordCount=0, frameCount=0.
  - state=PASS.
  - writeDataReady=0 while reset is low.
  - Reset mid-frame discards the partial frame and its partial sum. No trailer is emitted for it.
- Output stage:
  - One output register (oData, oValid, oLast).
  - The slot is free when !oValid || readDataReady.
  - An output beat transfers when readDataValid && readDataReady.
- Input acceptance: an input beat is accepted when writeDataValid && writeDataReady.
- Latency: an accepted input word appears on readData the next cycle.
- Protocol: once readDataValid=1, readData and readDataLast hold stable until readDataReady=1 (AXI-Stream rule).
- State PASS:
  - writeDataReady = slot free.
  - On accept: oData<=writeData, oLast<=0, oValid<=1.
  - sum<=sum+writeData (truncated to DataWidth).
  - wordCount<=wordCount+1 (saturating).
  - If writeDataLast=1 on that beat: state<=TRAIL.
  - If the slot is free and no input is accepted: oValid<=0.
- State TRAIL:
  - writeDataReady=0.
  - When the slot is free, in one cycle:
    - oData<=sum (the sum already includes the last data word), oLast<=1, oValid<=1.
    - sum<=0, wordCount<=0, frameCount<=frameCount+1.
    - state<=PASS.
- Throughput:
  - A frame of N words uses N+1 output beats.
  - With readDataReady held at 1: one input bubble per frame, during the TRAIL cycle.
  - The next frame's first word is accepted the cycle after the trailer is loaded.
- Single-word frame (first word has Last=1): the output is that word, then a trailer equal to the same word.
- Sum overflow wraps modulo 2^DataWidth. There is no error flag.
- A zero-length frame cannot occur, since Last is only defined on a data word. No trailer is emitted without at least one accepted word.
- Simultaneous events:
  - In PASS, output transfer and new input accept in the same cycle are allowed. The register reloads and oValid stays 1.
  - In TRAIL, a trailer load coincides with the data word leaving the register.
- Backpressure: readDataReady=0 holds the register and deasserts writeDataReady. No data is lost or duplicated.
- frameCount wraps from 2^CountWidth-1 to 0.

Test Plan:
1. Reset held low 3 cycles with writeDataValid=1 -> writeDataReady=0, readDataValid=0, frameCount=0. After release, the first word is accepted.
2. Frame 0x1,0x2,0x3 (Last on 0x3), readDataReady=1 -> output 0x1,0x2,0x3 with Last=0, then 0x6 with Last=1. frameCount=1; input bubble of exactly 1 cycle.
3. Frame 0xFFFFFFFF,0x00000002 (Last) -> trailer 0x00000001 (wrap). Then single-word frame 0xA5 (Last) -> output 0xA5, then trailer 0xA5 with Last=1.
4. Random readDataReady (50%) over 200 frames of random length 1..64 -> scoreboard exact match, readData/readDataLast stable while stalled. frameCount=200 at end (mod 2^16).
5. Reset pulled low after 2 words of a 5-word frame, then clean frame 0x10,0x20 (Last) -> only 0x10,0x20 and trailer 0x30 are emitted; no stale sum.
6. readDataReady=0 for 10 cycles during TRAIL, then 1 -> trailer emitted once, no input accepted while stalled, next frame starts the following cycle.
